core_multicycle: RTL
====================

CORE_MULTICYCLE -- requirements
Module: core_multicycle

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath and register width.
REQ-002 SHALL have parameter NREGS, default 32, register-file depth (power of two, 2..32); rs/rd indices taken modulo NREGS.
REQ-003 SHALL have parameter MEM_SIZE, default 64, instruction memory size in bytes (multiple of 4).
REQ-004 SHALL have parameter TICK_DIV, default 50000000, sys_clk cycles between instruction starts in run mode (>=5).
REQ-005 SHALL have port sys_clk  input  1  the only clock; all state on its rising edge.
REQ-006 SHALL have port sys_rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port button  input  1  raw asynchronous step request.
REQ-008 SHALL have port run_mode  input  1  1 = free-run paced by TICK_DIV, 0 = single-step on button.
REQ-009 SHALL have port imem_addr  output  32  byte address of instruction to fetch (pc).
REQ-010 SHALL have port imem_data  input  32  instruction word, valid one cycle after imem_addr changes.
REQ-011 SHALL have port result  output  XLEN  last value written to a register (held between writes).
REQ-012 SHALL have port retire  output  1  one-cycle pulse when an instruction completes.
REQ-013 SHALL have port halted  output  1  high once ECALL executed.

Function
REQ-014 SHALL synchronise button through two flops and detect rising edge, producing one step request per press.
REQ-015 SHALL run FSM IDLE -> FETCH -> DECODE -> EXEC -> WB -> IDLE; HALT terminal until reset.
REQ-016 IDLE SHALL leave on a step request (run_mode=0) or on pace-counter expiry (run_mode=1); requests arriving outside IDLE are discarded, not queued.
REQ-017 Pace counter SHALL count 0..TICK_DIV-1 continuously, expire at TICK_DIV-1, and clear on entering run_mode.
REQ-018 FETCH SHALL latch imem_data into the instruction register at end of the cycle.
REQ-019 DECODE SHALL read rs1/rs2 and sign-extend imm[31:20] for OP-IMM and the B-type immediate for branches.
REQ-020 EXEC SHALL support opcode 0110011 (OP) and 0010011 (OP-IMM): ADD, SUB (OP with bit30=1 only), SLL, SLT, SLTU, XOR, SRL, SRA (bit30), OR, AND; shift amount = operand_b[log2(XLEN)-1:0].
REQ-021 EXEC SHALL support 1100011 func3 000 BEQ and 001 BNE; other branch func3 SHALL behave as not-taken.
REQ-022 Instruction 0x00000073 SHALL enter HALT, assert halted, pulse retire once, leave pc unchanged.
REQ-023 Any other opcode SHALL execute as NOP (pc advances, no write, retire pulses).
REQ-024 WB SHALL write rd only for OP/OP-IMM with rd!=0; register 0 SHALL always read 0.
REQ-025 WB SHALL update pc: taken branch -> (pc+imm) mod MEM_SIZE; else pc+4, wrapping to 0 when pc+4 >= MEM_SIZE.
REQ-026 retire SHALL pulse for exactly one cycle in WB; latency start-to-retire = 4 cycles.
REQ-027 result SHALL update in the same cycle as the register write and be unaffected by non-writing instructions.
REQ-028 Arithmetic SHALL be modulo 2^XLEN; overflow ignored.

Reset
REQ-029 While sys_rst=0: state IDLE, pc=0, all registers 0, result=0, retire=0, halted=0, pace counter 0, sync flops 0.
REQ-030 Reset asserted mid-instruction SHALL abort it with no register or pc update.

Verification
REQ-031 Reset, run_mode=0, three button presses over ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2 -> result 5, 0xFFFFFFFD, 2; pc 12; three retire pulses.
REQ-032 SUB x4,x2,x1 then SRA x5,x2,1 (x1=5,x2=-3) -> result 0xFFFFFFF8 then 0xFFFFFFFE; SLTU x6,x1,x2 -> 1.
REQ-033 pc=60 with MEM_SIZE=64, NOP retires -> pc=0; BEQ x0,x0,-8 at pc=8 -> pc=0; BNE x0,x0 -> pc=pc+4.
REQ-034 ADDI x0,x0,7 -> x0 reads 0, result unchanged, retire pulses.
REQ-035 run_mode=1, TICK_DIV=10 -> retire every 10 cycles; button held high -> one step only; presses during EXEC ignored.
REQ-036 ECALL -> halted=1, no further retires across 100 ticks; sys_rst pulse low during EXEC -> pc=0, regs 0, halted=0.

Source files
------------

// File: rtl/core_multicycle.sv
// Multicycle RV32I-subset core: IDLE/FETCH/DECODE/EXEC/WB sequencing, stepped by a
// debounced-free button edge or paced by a free-running tick counter.
module core_multicycle #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int MEM_SIZE = 64,
    parameter int TICK_DIV = 50000000
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic            button,
    input  logic            run_mode,
    output logic [31:0]     imem_addr,
    input  logic [31:0]     imem_data,
    output logic [XLEN-1:0] result,
    output logic            retire,
    output logic            halted
);
    localparam int RIDX = $clog2(NREGS);
    localparam int SHW  = $clog2(XLEN);
    localparam int PW   = $clog2(TICK_DIV);
    localparam logic [39:0] MEM40  = 40'(MEM_SIZE);
    // Bias keeps pc+imm positive for any 13-bit branch offset before the modulo.
    localparam logic [39:0] BIAS40 = 40'(MEM_SIZE * (4096 / MEM_SIZE + 2));

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;

    state_t            r_state, w_next;
    logic              r_btn_s1, r_btn_s2, r_btn_d;
    logic [PW-1:0]     r_pace;
    logic              r_run_d;
    logic [31:0]       r_pc, r_ir;
    logic [XLEN-1:0]   r_a, r_b, r_alu, r_result;
    logic [12:0]       r_bimm;
    logic              r_taken;
    logic [XLEN-1:0]   r_regs [NREGS];

    logic              w_step, w_tick, w_go;
    logic [6:0]        w_opc;
    logic [2:0]        w_f3;
    logic              w_is_op, w_is_opimm, w_is_br, w_ecall, w_wen;
    logic [RIDX-1:0]   w_rs1, w_rs2, w_rd;
    logic [SHW-1:0]    w_shamt;
    logic [XLEN-1:0]   w_alu;
    logic [31:0]       w_pc4, w_pc_seq, w_br_pc;
    logic [39:0]       w_br_sum;

    assign w_step = r_btn_s2 & ~r_btn_d;
    assign w_tick = (r_pace == PW'(TICK_DIV - 1));
    assign w_go   = run_mode ? w_tick : w_step;

    assign w_opc      = r_ir[6:0];
    assign w_f3       = r_ir[14:12];
    assign w_is_op    = (w_opc == 7'b0110011);
    assign w_is_opimm = (w_opc == 7'b0010011);
    assign w_is_br    = (w_opc == 7'b1100011);
    assign w_ecall    = (r_ir == 32'h0000_0073);
    assign w_rs1      = r_ir[15 +: RIDX];
    assign w_rs2      = r_ir[20 +: RIDX];
    assign w_rd       = r_ir[7 +: RIDX];
    assign w_wen      = (w_is_op | w_is_opimm) && (w_rd != '0);
    assign w_shamt    = r_b[SHW-1:0];

    always_comb begin
        w_alu = '0;
        case (w_f3)
            3'd0: w_alu = (w_is_op && r_ir[30]) ? r_a - r_b : r_a + r_b;
            3'd1: w_alu = r_a << w_shamt;
            3'd2: w_alu = XLEN'($signed(r_a) < $signed(r_b));
            3'd3: w_alu = XLEN'(r_a < r_b);
            3'd4: w_alu = r_a ^ r_b;
            3'd5: w_alu = r_ir[30] ? XLEN'($signed(r_a) >>> w_shamt) : r_a >> w_shamt;
            3'd6: w_alu = r_a | r_b;
            3'd7: w_alu = r_a & r_b;
            default: w_alu = '0;
        endcase
    end

    assign w_pc4    = r_pc + 32'd4;
    assign w_pc_seq = (w_pc4 >= 32'(MEM_SIZE)) ? 32'd0 : w_pc4;
    assign w_br_sum = {8'd0, r_pc} + {{27{r_bimm[12]}}, r_bimm} + BIAS40;
    assign w_br_pc  = 32'(w_br_sum % MEM40);

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_go) w_next = S_FETCH;
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: w_next = S_EXEC;
            S_EXEC:   w_next = S_WB;
            S_WB:     w_next = w_ecall ? S_HALT : S_IDLE;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_IDLE;
        endcase
    end

    // Pace counter restarts at 0 on the cycle run_mode is first seen high.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_btn_s1 <= 1'b0;
            r_btn_s2 <= 1'b0;
            r_btn_d  <= 1'b0;
            r_run_d  <= 1'b0;
            r_pace   <= '0;
        end else begin
            r_btn_s1 <= button;
            r_btn_s2 <= r_btn_s1;
            r_btn_d  <= r_btn_s2;
            r_run_d  <= run_mode;
            if ((run_mode && !r_run_d) || w_tick) r_pace <= '0;
            else                                  r_pace <= r_pace + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_pc     <= '0;
            r_ir     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_bimm   <= '0;
            r_alu    <= '0;
            r_taken  <= 1'b0;
            r_result <= '0;
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else begin
            case (r_state)
                S_FETCH: r_ir <= imem_data;
                S_DECODE: begin
                    r_a    <= r_regs[w_rs1];
                    r_b    <= w_is_opimm ? {{(XLEN-12){r_ir[31]}}, r_ir[31:20]} : r_regs[w_rs2];
                    r_bimm <= {r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
                end
                S_EXEC: begin
                    r_alu   <= w_alu;
                    r_taken <= w_is_br && ((w_f3 == 3'd0 && r_a == r_b) ||
                                           (w_f3 == 3'd1 && r_a != r_b));
                end
                S_WB: begin
                    if (w_wen) begin
                        r_regs[w_rd] <= r_alu;
                        r_result     <= r_alu;
                    end
                    if (!w_ecall) r_pc <= r_taken ? w_br_pc : w_pc_seq;
                end
                default: ;
            endcase
        end
    end

    assign imem_addr = r_pc;
    assign result    = r_result;
    assign retire    = (r_state == S_WB);
    assign halted    = (r_state == S_HALT);
endmodule
